// File: rtl/sram_wait_ctrl.sv
// Synchronous 32-bit SRAM model with programmable wait states and beat-pacing strobes.
// Optional per-byte even parity storage/checking is enabled by defining SRAM_PARITY_EN.
module sram_wait_ctrl #(
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned WAIT_CYC  = 1,
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 CEB,
  input  logic                 WEB,
  input  logic [ADDR_BITS-1:0] A,
  input  logic [31:0]          DI,
  input  logic [3:0]           BWEB,
  output logic [31:0]          DO,
  output logic                 read_en,
  output logic                 write_en,
  output logic                 addr_err,
  output logic                 par_err
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [2:0]  WAIT_LD = 3'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt;
  logic               is_wr;
  logic [IDX_W-1:0]   widx;
  logic               oor;

  logic [31:0]        mem [DEPTH];

  logic [IDX_W-1:0]   a_idx;
  logic               a_oor;
  logic               accept;
  logic               enter_done;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_oor;
  logic [31:0]        rd_word;
  logic               wr_commit;

  assign a_idx = A[IDX_W+1:2];
  assign a_oor = (A >> (IDX_W + 2)) != '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!CEB) begin
          accept  = 1'b1;
          cnt_nxt = WAIT_LD;
          state_nxt = (WAIT_CYC == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states DONE is entered straight from IDLE, so the access
  // attributes come from the bus rather than from the latched copies.
  always_comb begin
    enter_done = (state_nxt == S_DONE);
    acc_wr     = (state == S_IDLE) ? ~WEB  : is_wr;
    acc_idx    = (state == S_IDLE) ? a_idx : widx;
    acc_oor    = (state == S_IDLE) ? a_oor : oor;
    rd_word    = mem[acc_idx];
    wr_commit  = (state == S_DONE) && is_wr && !CEB && !WEB && !oor && !a_oor;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_wr    <= 1'b0;
      widx     <= '0;
      oor      <= 1'b0;
      DO       <= '0;
      read_en  <= 1'b0;
      write_en <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (accept) begin
        is_wr <= ~WEB;
        widx  <= a_idx;
        oor   <= a_oor;
      end
      read_en  <= enter_done && !acc_wr;
      write_en <= enter_done && acc_wr;
      addr_err <= enter_done && acc_oor;
      if (enter_done && !acc_wr) DO <= acc_oor ? '0 : rd_word;
    end
  end

  // Storage has no reset; contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!BWEB[i]) mem[a_idx][8*i +: 8] <= DI[8*i +: 8];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_calc;

  always_comb begin
    par_calc = '0;
    for (int unsigned i = 0; i < 4; i++) par_calc[i] = ^rd_word[8*i +: 8];
  end

  always_ff @(posedge ACLK) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!BWEB[i]) par_mem[a_idx][i] <= ^DI[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) par_err <= 1'b0;
    else        par_err <= enter_done && !acc_wr && !acc_oor && (par_calc != par_mem[acc_idx]);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_wait_ctrl.sv
// Self-checking bench for sram_wait_ctrl: two instances (WAIT_CYC=0 and 1) checked
// against a word-array reference model with randomized traffic.
module tb_sram_wait_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int          WC1   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ceb  [2];
  logic        web  [2];
  logic [31:0] a    [2];
  logic [31:0] di   [2];
  logic [3:0]  bweb [2];
  logic [31:0] dout [2];
  logic        ren  [2];
  logic        wen  [2];
  logic        aerr [2];
  logic        perr [2];

  logic [31:0] model   [2][DEPTH];
  logic [31:0] last_do [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_wait_ctrl #(.DEPTH(DEPTH), .WAIT_CYC(0), .ADDR_BITS(32)) u_dut0 (
    .ACLK(clk), .ARESET(rst), .CEB(ceb[0]), .WEB(web[0]), .A(a[0]), .DI(di[0]),
    .BWEB(bweb[0]), .DO(dout[0]), .read_en(ren[0]), .write_en(wen[0]),
    .addr_err(aerr[0]), .par_err(perr[0])
  );

  sram_wait_ctrl #(.DEPTH(DEPTH), .WAIT_CYC(WC1), .ADDR_BITS(32)) u_dut1 (
    .ACLK(clk), .ARESET(rst), .CEB(ceb[1]), .WEB(web[1]), .A(a[1]), .DI(di[1]),
    .BWEB(bweb[1]), .DO(dout[1]), .read_en(ren[1]), .write_en(wen[1]),
    .addr_err(aerr[1]), .par_err(perr[1])
  );

  function automatic int wc(input int k);
    return (k == 0) ? 0 : WC1;
  endfunction

  function automatic bit is_oor(input logic [31:0] addr);
    return addr >= 4 * DEPTH;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: a write lands only in range, only on bytes whose enable is low.
  task automatic model_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
    int idx;
    if (is_oor(addr)) return;
    idx = int'(addr / 4);
    for (int i = 0; i < 4; i++)
      if (!be[i]) model[k][idx][8*i +: 8] = data[8*i +: 8];
  endtask

  // Drives one access from IDLE and observes the following wc+3 cycles.
  // WAIT cycles get random bus noise, which the DUT must ignore.
  task automatic run_access(input int k, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be,
                            output int lat, output int nstb, output int nbad,
                            output logic [31:0] dv, output logic ae, output logic pe);
    int w;
    w = wc(k);
    lat = -1; nstb = 0; nbad = 0; dv = '0; ae = 1'b0; pe = 1'b0;
    ceb[k] = 1'b0; web[k] = ~wr; a[k] = addr; di[k] = data; bweb[k] = be;
    for (int n = 1; n <= w + 3; n++) begin
      cyc();
      if ((wr ? wen[k] : ren[k]) === 1'b1) begin
        nstb++;
        if (lat < 0) lat = n;
        dv = dout[k]; ae = aerr[k]; pe = perr[k];
      end else if (aerr[k] !== 1'b0 || perr[k] !== 1'b0) nbad++;
      if ((wr ? ren[k] : wen[k]) !== 1'b0) nbad++;
      if (n < w + 1) begin
        ceb[k] = 1'($urandom); web[k] = 1'($urandom); a[k] = $urandom;
        di[k] = $urandom; bweb[k] = 4'($urandom);
      end else if (n == w + 1 && wr) begin
        ceb[k] = 1'b0; web[k] = 1'b0; a[k] = addr; di[k] = data; bweb[k] = be;
      end else ceb[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ceb[k] = 1'b1; web[k] = 1'b1; a[k] = '0; di[k] = '0; bweb[k] = '1;
      last_do[k] = '0;
    end
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({dout[k], ren[k], wen[k], aerr[k], perr[k]} !== 36'h0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got DO=%h re=%b we=%b ae=%b pe=%b, want all 0",
                 k, dout[k], ren[k], wen[k], aerr[k], perr[k]);
      end
    end
    #4 rst = 1'b0;
    cyc();
  endtask

  task automatic test_init();
    int lat, nstb, nbad;
    logic [31:0] dv, data;
    logic ae, pe;
    int bad = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(DEPTH); i++) begin
        data = $urandom;
        run_access(k, 1'b1, 32'(4 * i), data, 4'b0000, lat, nstb, nbad, dv, ae, pe);
        model_write(k, 32'(4 * i), data, 4'b0000);
        if (nstb != 1 || nbad != 0 || lat != wc(k) + 1) bad++;
      end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL init_writes: %0d writes with wrong strobe timing, want 0", bad);
    end
  endtask

  task automatic test_write_read();
    int lat, nstb, nbad;
    logic [31:0] dv;
    logic ae, pe;
    run_access(1, 1'b1, 32'h10, 32'hA5A5_1234, 4'b0000, lat, nstb, nbad, dv, ae, pe);
    model_write(1, 32'h10, 32'hA5A5_1234, 4'b0000);
    n_cmp++;
    if (lat != 2 || nstb != 1 || nbad != 0) begin
      n_err++;
      $display("FAIL wr_latency: lat=%0d pulses=%0d stray=%0d, want 2/1/0", lat, nstb, nbad);
    end
    n_cmp++;
    if (dv !== last_do[1]) begin
      n_err++;
      $display("FAIL wr_do_hold: DO=%h, want %h", dv, last_do[1]);
    end
    run_access(1, 1'b0, 32'h10, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (lat != 2 || nstb != 1 || nbad != 0) begin
      n_err++;
      $display("FAIL rd_latency: lat=%0d pulses=%0d stray=%0d, want 2/1/0", lat, nstb, nbad);
    end
    n_cmp++;
    if (dv !== 32'hA5A5_1234) begin
      n_err++;
      $display("FAIL rd_data: DO=%h, want a5a51234", dv);
    end
    last_do[1] = 32'hA5A5_1234;
  endtask

  task automatic test_partial();
    int lat, nstb, nbad;
    logic [31:0] dv;
    logic ae, pe;
    run_access(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b1100, lat, nstb, nbad, dv, ae, pe);
    model_write(1, 32'h10, 32'hFFFF_FFFF, 4'b1100);
    run_access(1, 1'b0, 32'h10, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (dv !== 32'hA5A5_FFFF) begin
      n_err++;
      $display("FAIL partial_bweb1100: DO=%h, want a5a5ffff", dv);
    end
    last_do[1] = dv;
    run_access(1, 1'b1, 32'h10, 32'h0000_0000, 4'b1111, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (nstb != 1 || lat != 2) begin
      n_err++;
      $display("FAIL bweb1111_strobe: pulses=%0d lat=%0d, want 1/2", nstb, lat);
    end
    run_access(1, 1'b0, 32'h10, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (dv !== 32'hA5A5_FFFF) begin
      n_err++;
      $display("FAIL bweb1111_data: DO=%h, want a5a5ffff", dv);
    end
    last_do[1] = 32'hA5A5_FFFF;
  endtask

  task automatic test_burst();
    ceb[0] = 1'b0; web[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      a[0] = 32'(4 * j);
      cyc();
      n_cmp++;
      if (ren[0] !== 1'b1 || wen[0] !== 1'b0 || dout[0] !== model[0][j]) begin
        n_err++;
        $display("FAIL burst_beat%0d: re=%b we=%b DO=%h, want 1/0/%h", j, ren[0], wen[0],
                 dout[0], model[0][j]);
      end
      a[0] = $urandom;
      cyc();
      n_cmp++;
      if (ren[0] !== 1'b0 || dout[0] !== model[0][j]) begin
        n_err++;
        $display("FAIL burst_gap%0d: re=%b DO=%h, want 0/%h", j, ren[0], dout[0], model[0][j]);
      end
    end
    ceb[0] = 1'b1;
    last_do[0] = model[0][3];
  endtask

  task automatic test_oor();
    int lat, nstb, nbad;
    logic [31:0] dv;
    logic ae, pe;
    run_access(1, 1'b0, 32'(4 * DEPTH), '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (dv !== 32'h0 || ae !== 1'b1 || nstb != 1) begin
      n_err++;
      $display("FAIL oor_read: DO=%h ae=%b pulses=%0d, want 0/1/1", dv, ae, nstb);
    end
    last_do[1] = '0;
    run_access(1, 1'b1, 32'(4 * DEPTH), 32'hDEAD_BEEF, 4'b0000, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (ae !== 1'b1 || nstb != 1 || nbad != 0) begin
      n_err++;
      $display("FAIL oor_write: ae=%b pulses=%0d stray=%0d, want 1/1/0", ae, nstb, nbad);
    end
    run_access(1, 1'b0, 32'h0, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (dv !== model[1][0] || ae !== 1'b0) begin
      n_err++;
      $display("FAIL oor_no_wrap: DO=%h ae=%b, want %h/0", dv, ae, model[1][0]);
    end
    last_do[1] = model[1][0];
  endtask

  task automatic test_reset_abort();
    int lat, nstb, nbad, wseen;
    logic [31:0] dv;
    logic ae, pe;
    ceb[1] = 1'b0; web[1] = 1'b0; a[1] = 32'h20; di[1] = ~model[1][8]; bweb[1] = 4'b0000;
    cyc();
    ceb[1] = 1'b0; web[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({dout[1], ren[1], wen[1], aerr[1]} !== 35'h0) begin
      n_err++;
      $display("FAIL abort_outputs: DO=%h re=%b we=%b ae=%b, want all 0",
               dout[1], ren[1], wen[1], aerr[1]);
    end
    last_do[0] = '0; last_do[1] = '0;
    wseen = 0;
    repeat (2) begin
      cyc();
      if (wen[1] !== 1'b0) wseen++;
    end
    #3 rst = 1'b0;
    ceb[1] = 1'b1;
    repeat (3) begin
      cyc();
      if (wen[1] !== 1'b0) wseen++;
    end
    n_cmp++;
    if (wseen != 0) begin
      n_err++;
      $display("FAIL abort_no_write_en: %0d write_en cycles, want 0", wseen);
    end
    run_access(1, 1'b0, 32'h20, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (dv !== model[1][8] || lat != 2) begin
      n_err++;
      $display("FAIL abort_mem_unchanged: DO=%h lat=%0d, want %h/2", dv, lat, model[1][8]);
    end
    last_do[1] = model[1][8];
  endtask

  task automatic test_random();
    int lat, nstb, nbad, k;
    bit wr, oor;
    logic [31:0] addr, data, dv, exp_do;
    logic [3:0] be;
    logic ae, pe;
    for (int t = 0; t < 60; t++) begin
      k    = int'($urandom_range(1, 0));
      wr   = 1'($urandom);
      addr = ($urandom_range(7, 0) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(4 * DEPTH - 1, 0));
      data = $urandom;
      be   = 4'($urandom);
      oor  = is_oor(addr);
      exp_do = wr ? last_do[k] : (oor ? 32'h0 : model[k][addr / 4]);
      run_access(k, wr, addr, data, be, lat, nstb, nbad, dv, ae, pe);
      if (wr) model_write(k, addr, data, be);
      else last_do[k] = exp_do;
      n_cmp++;
      if (lat != wc(k) + 1 || nstb != 1 || nbad != 0) begin
        n_err++;
        $display("FAIL rand_timing[%0d] k=%0d wr=%0b: lat=%0d pulses=%0d stray=%0d, want %0d/1/0",
                 t, k, wr, lat, nstb, nbad, wc(k) + 1);
      end
      n_cmp++;
      if (dv !== exp_do || ae !== oor || pe !== 1'b0) begin
        n_err++;
        $display("FAIL rand_data[%0d] k=%0d wr=%0b A=%h: DO=%h ae=%b pe=%b, want %h/%b/0",
                 t, k, wr, addr, dv, ae, pe, exp_do, oor);
      end
    end
  endtask

  task automatic test_parity();
    int lat, nstb, nbad;
    logic [31:0] dv;
    logic ae, pe;
    run_access(1, 1'b1, 32'h14, 32'h0000_0001, 4'b0000, lat, nstb, nbad, dv, ae, pe);
    model_write(1, 32'h14, 32'h0000_0001, 4'b0000);
`ifdef SRAM_PARITY_EN
    u_dut1.mem[5] = u_dut1.mem[5] ^ 32'h0000_0100;
    run_access(1, 1'b0, 32'h14, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (pe !== 1'b1 || dv !== 32'h0000_0101 || nbad != 0) begin
      n_err++;
      $display("FAIL parity_detect: pe=%b DO=%h stray=%0d, want 1/00000101/0", pe, dv, nbad);
    end
`else
    run_access(1, 1'b0, 32'h14, '0, 4'hF, lat, nstb, nbad, dv, ae, pe);
    n_cmp++;
    if (pe !== 1'b0 || perr[1] !== 1'b0 || dv !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL parity_off: pe=%b DO=%h, want 0/00000001", pe, dv);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_partial();
    test_burst();
    test_oor();
    test_reset_abort();
    test_random();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
